// File: rtl/tx_send_ctrl.sv
// tx_send_ctrl: push-button front end for the serial transmitter.
// Synchronizes and debounces the active-low key, turns each accepted press
// into a one-cycle send strobe with the switch byte latched alongside it,
// then holds off further sends for one frame.
module tx_send_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAME_CYCLES    = 10,
  parameter int DATA_W          = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetN,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw_data,
  output logic              send,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        press_count
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(FRAME_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        state, state_nxt;
  logic          key_meta, key_s, key_db;
  logic [CW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic          press;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_s    <= key_meta;
    end
  end

  // Debouncer: a new level must persist DEBOUNCE_CYCLES edges; any bounce
  // back to the current level restarts the count.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      key_db <= 1'b1;
      db_cnt <= '0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      key_db <= key_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  // Only the falling (pressed) debounced transition is an event; releases are ignored.
  assign press = (key_s != key_db) && (db_cnt == DB_LAST) && !key_s;

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and Moore outputs; outputs derive from state alone so reset clears them at once.
  always_comb begin
    state_nxt = state;
    send      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: if (press) state_nxt = SEND;
      SEND: begin
        send      = 1'b1;
        busy      = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (hold_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data capture, send counter, holdoff counter and sticky overrun flag.
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      tx_data     <= '0;
      press_count <= '0;
      hold_cnt    <= '0;
      overrun     <= 1'b0;
    end else begin
      if (press && state == IDLE) tx_data <= sw_data;
      if (press && state != IDLE) overrun <= 1'b1;
      if (state == SEND) begin
        press_count <= press_count + 8'd1;
        hold_cnt    <= HOLD_INIT;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_send_ctrl.sv
// Directed bench for tx_send_ctrl with DEBOUNCE_CYCLES=4, FRAME_CYCLES=12.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_tx_send_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic [7:0] sw_data;
  logic       send, busy, overrun;
  logic [7:0] tx_data, press_count;

  int n_chk = 0;
  int n_err = 0;
  int n_send, n_busy;

  tx_send_ctrl #(.DEBOUNCE_CYCLES(4), .FRAME_CYCLES(12), .DATA_W(8)) dut (
    .CLOCK_50(clk), .resetN(rst_n), .key_n(key_n), .sw_data(sw_data),
    .send(send), .tx_data(tx_data), .busy(busy), .overrun(overrun),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n edges, tallying cycles with send and busy high.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (send) n_send++;
      if (busy) n_busy++;
    end
  endtask

  // Release the key and let the debouncer return to released.
  task automatic release_key();
    key_n = 1'b1;
    run(10);
  endtask

  initial begin
    rst_n = 1'b0; key_n = 1'b1; sw_data = 8'h00;
    #2;
    chk("rst_send", send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx",   tx_data, 0);
    chk("rst_cnt",  press_count, 0);
    chk("rst_ovr",  overrun, 0);
    run(3);
    rst_n = 1'b1;
    run(3);

    // Clean press: send on the 6th edge after key low, busy 13 cycles.
    sw_data = 8'hA5; key_n = 1'b0; n_send = 0; n_busy = 0;
    run(5);
    chk("clean_nosend_early", send, 0);
    run(1);
    chk("clean_send", send, 1);
    chk("clean_tx", tx_data, 8'hA5);
    run(1);
    chk("clean_send_1cyc", send, 0);
    chk("clean_cnt", press_count, 1);
    run(20);
    chk("clean_busy_len", n_busy, 13);
    chk("clean_nsend", n_send, 1);
    chk("clean_ovr", overrun, 0);
    release_key();

    // Bounce: no low run long enough, then a held press gives one send.
    n_send = 0;
    key_n = 1'b0; run(3);
    key_n = 1'b1; run(1);
    key_n = 1'b0; run(2);
    key_n = 1'b1; run(10);
    chk("bounce_nosend", n_send, 0);
    chk("bounce_cnt", press_count, 1);
    key_n = 1'b0; run(25);
    chk("bounce_held_send", n_send, 1);
    chk("bounce_cnt2", press_count, 2);
    release_key();

    // Data capture: switches change right after the capturing edge.
    n_send = 0;
    sw_data = 8'h3C; key_n = 1'b0;
    run(6);
    sw_data = 8'hFF;
    chk("cap_send", send, 1);
    chk("cap_tx_send", tx_data, 8'h3C);
    run(6);
    chk("cap_tx_hold", tx_data, 8'h3C);
    run(15);
    chk("cap_tx_after", tx_data, 8'h3C);
    chk("cap_nsend", n_send, 1);
    release_key();

    // Overrun: second press lands in HOLD and is dropped.
    n_send = 0;
    sw_data = 8'h5A; key_n = 1'b0; run(6);
    sw_data = 8'h11; key_n = 1'b1; run(5);
    key_n = 1'b0; run(6);
    chk("ovr_busy_still", busy, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_tx", tx_data, 8'h5A);
    key_n = 1'b1; run(15);
    chk("ovr_nsend", n_send, 1);
    chk("ovr_cnt", press_count, 4);
    sw_data = 8'h77; key_n = 1'b0; run(25);
    chk("ovr_later_send", n_send, 2);
    chk("ovr_later_tx", tx_data, 8'h77);
    chk("ovr_sticky", overrun, 1);
    release_key();

    // Wrap: 256 presses from a clean reset.
    rst_n = 1'b0; #2;
    chk("rst2_ovr", overrun, 0);
    chk("rst2_cnt", press_count, 0);
    run(2); rst_n = 1'b1; run(2);
    n_send = 0;
    for (int i = 1; i <= 256; i++) begin
      sw_data = 8'(i);
      key_n = 1'b0; run(20);
      key_n = 1'b1; run(8);
      if (i == 255) chk("wrap_255", press_count, 8'hFF);
    end
    chk("wrap_256", press_count, 8'h00);
    chk("wrap_nsend", n_send, 256);
    chk("wrap_tx", tx_data, 8'h00);

    // Reset mid-HOLD with key held low.
    sw_data = 8'hC3; key_n = 1'b0;
    run(6);   // SEND
    run(5);   // HOLD cycle 5
    chk("mid_busy_pre", busy, 1);
    chk("mid_cnt_pre", press_count, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_send", send, 0);
    chk("mid_busy", busy, 0);
    chk("mid_tx", tx_data, 0);
    chk("mid_cnt", press_count, 0);
    run(2);
    rst_n = 1'b1; n_send = 0;
    run(5);
    chk("mid_nosend_early", send, 0);
    run(1);
    chk("mid_send_6", send, 1);
    run(25);
    chk("mid_nsend", n_send, 1);
    chk("mid_cnt_after", press_count, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
